// File: rtl/alu_exec_stage_if.sv
// Execute-stage bus: the Decode-stage decoder fields, the ALU operands and
// result, and the EXE/MEM pipeline register inputs and registered outputs.
interface alu_exec_stage_if;
    logic        enable;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [3:0]  alu_op_d;
    logic [3:0]  alu_op;
    logic [31:0] oprd1;
    logic [31:0] oprd2;
    logic [4:0]  shamt;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] reg_data2_e;
    logic [4:0]  write_reg_e;
    logic        reg_write_e;
    logic        mem_to_reg_e;
    logic        mem_write_e;
    logic        mem_read_e;
    logic        load_full_word_e;
    logic        load_signed_e;
    logic [31:0] reg_data2_m;
    logic [31:0] alu_result_m;
    logic [4:0]  write_reg_m;
    logic        reg_write_m;
    logic        mem_to_reg_m;
    logic        mem_write_m;
    logic        mem_read_m;
    logic        load_full_word_m;
    logic        load_signed_m;

    modport master (
        output enable, opcode, funct, alu_op, oprd1, oprd2, shamt,
               reg_data2_e, write_reg_e, reg_write_e, mem_to_reg_e,
               mem_write_e, mem_read_e, load_full_word_e, load_signed_e,
        input  alu_op_d, alu_result, alu_zero, reg_data2_m, alu_result_m,
               write_reg_m, reg_write_m, mem_to_reg_m, mem_write_m,
               mem_read_m, load_full_word_m, load_signed_m
    );

    modport slave (
        input  enable, opcode, funct, alu_op, oprd1, oprd2, shamt,
               reg_data2_e, write_reg_e, reg_write_e, mem_to_reg_e,
               mem_write_e, mem_read_e, load_full_word_e, load_signed_e,
        output alu_op_d, alu_result, alu_zero, reg_data2_m, alu_result_m,
               write_reg_m, reg_write_m, mem_to_reg_m, mem_write_m,
               mem_read_m, load_full_word_m, load_signed_m
    );
endinterface

// File: rtl/alu_exec_stage.sv
// MIPS execute stage: ALU-op decoder (feeds ID/EX upstream), 32-bit ALU and
// the EXE/MEM pipeline register handing results to the Memory stage.
module alu_exec_stage (
    input  logic              clk,
    input  logic              reset,
    alu_exec_stage_if.slave   bus
);
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SRA  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd12;

    logic [3:0]  alu_op_d_s;
    logic [31:0] alu_result_s;

    logic [31:0] reg_data2_r;
    logic [31:0] alu_result_r;
    logic [4:0]  write_reg_r;
    logic        reg_write_r;
    logic        mem_to_reg_r;
    logic        mem_write_r;
    logic        mem_read_r;
    logic        load_full_word_r;
    logic        load_signed_r;

    // Decode opcode/funct into the ALU op; anything unrecognised adds, which
    // also covers address generation for loads and stores.
    always_comb begin
        alu_op_d_s = OP_ADD;
        case (bus.opcode)
            6'h00: begin
                case (bus.funct)
                    6'h20, 6'h21: alu_op_d_s = OP_ADD;
                    6'h22, 6'h23: alu_op_d_s = OP_SUB;
                    6'h24:        alu_op_d_s = OP_AND;
                    6'h25:        alu_op_d_s = OP_OR;
                    6'h26:        alu_op_d_s = OP_XOR;
                    6'h27:        alu_op_d_s = OP_NOR;
                    6'h2A:        alu_op_d_s = OP_SLT;
                    6'h2B:        alu_op_d_s = OP_SLTU;
                    6'h00:        alu_op_d_s = OP_SLL;
                    6'h02:        alu_op_d_s = OP_SRL;
                    6'h03:        alu_op_d_s = OP_SRA;
                    default:      alu_op_d_s = OP_ADD;
                endcase
            end
            6'h08, 6'h09: alu_op_d_s = OP_ADD;
            6'h0A:        alu_op_d_s = OP_SLT;
            6'h0B:        alu_op_d_s = OP_SLTU;
            6'h0C:        alu_op_d_s = OP_AND;
            6'h0D:        alu_op_d_s = OP_OR;
            6'h0E:        alu_op_d_s = OP_XOR;
            6'h04, 6'h05: alu_op_d_s = OP_SUB;
            default:      alu_op_d_s = OP_ADD;
        endcase
    end

    // ALU datapath: shifts use oprd2 and shamt only; add/sub wrap silently.
    always_comb begin
        alu_result_s = 32'd0;
        case (bus.alu_op)
            OP_AND:  alu_result_s = bus.oprd1 & bus.oprd2;
            OP_OR:   alu_result_s = bus.oprd1 | bus.oprd2;
            OP_ADD:  alu_result_s = bus.oprd1 + bus.oprd2;
            OP_SLL:  alu_result_s = bus.oprd2 << bus.shamt;
            OP_SRL:  alu_result_s = bus.oprd2 >> bus.shamt;
            OP_SRA:  alu_result_s = $unsigned($signed(bus.oprd2) >>> bus.shamt);
            OP_SUB:  alu_result_s = bus.oprd1 - bus.oprd2;
            OP_SLT:  alu_result_s = ($signed(bus.oprd1) < $signed(bus.oprd2)) ? 32'd1 : 32'd0;
            OP_SLTU: alu_result_s = (bus.oprd1 < bus.oprd2) ? 32'd1 : 32'd0;
            OP_XOR:  alu_result_s = bus.oprd1 ^ bus.oprd2;
            OP_NOR:  alu_result_s = ~(bus.oprd1 | bus.oprd2);
            default: alu_result_s = 32'd0;
        endcase
    end

    // EXE/MEM register: reset wins over enable, enable captures, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_data2_r      <= 32'd0;
            alu_result_r     <= 32'd0;
            write_reg_r      <= 5'd0;
            reg_write_r      <= 1'b0;
            mem_to_reg_r     <= 1'b0;
            mem_write_r      <= 1'b0;
            mem_read_r       <= 1'b0;
            load_full_word_r <= 1'b0;
            load_signed_r    <= 1'b0;
        end else if (bus.enable) begin
            reg_data2_r      <= bus.reg_data2_e;
            alu_result_r     <= alu_result_s;
            write_reg_r      <= bus.write_reg_e;
            reg_write_r      <= bus.reg_write_e;
            mem_to_reg_r     <= bus.mem_to_reg_e;
            mem_write_r      <= bus.mem_write_e;
            mem_read_r       <= bus.mem_read_e;
            load_full_word_r <= bus.load_full_word_e;
            load_signed_r    <= bus.load_signed_e;
        end
    end

    assign bus.alu_op_d         = alu_op_d_s;
    assign bus.alu_result       = alu_result_s;
    assign bus.alu_zero         = (alu_result_s == 32'd0);
    assign bus.reg_data2_m      = reg_data2_r;
    assign bus.alu_result_m     = alu_result_r;
    assign bus.write_reg_m      = write_reg_r;
    assign bus.reg_write_m      = reg_write_r;
    assign bus.mem_to_reg_m     = mem_to_reg_r;
    assign bus.mem_write_m      = mem_write_r;
    assign bus.mem_read_m       = mem_read_r;
    assign bus.load_full_word_m = load_full_word_r;
    assign bus.load_signed_m    = load_signed_r;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: stimulus pushes expectations tagged
// with the cycle they become observable; a monitor pops them on negedges.
module tb_alu_exec_stage;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    alu_exec_stage_if bus ();

    alu_exec_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expectations.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    localparam int S_OPD  = 0;
    localparam int S_RES  = 1;
    localparam int S_ZERO = 2;
    localparam int S_RESM = 3;
    localparam int S_D2M  = 4;
    localparam int S_WRM  = 5;
    localparam int S_CTLM = 6;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_OPD:   return {28'd0, bus.alu_op_d};
            S_RES:   return bus.alu_result;
            S_ZERO:  return {31'd0, bus.alu_zero};
            S_RESM:  return bus.alu_result_m;
            S_D2M:   return bus.reg_data2_m;
            S_WRM:   return {27'd0, bus.write_reg_m};
            S_CTLM:  return {26'd0, bus.reg_write_m, bus.mem_to_reg_m, bus.mem_write_m,
                             bus.mem_read_m, bus.load_full_word_m, bus.load_signed_m};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic push(input string nm, input int sel, input logic [31:0] e, input int due);
        exp_t x;
        x.due = due; x.sel = sel; x.exp = e; x.name = nm;
        sb.push_back(x);
    endtask

    // Monitor: on each falling edge compare every expectation now due.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t x;
            logic [31:0] a;
            x = sb.pop_front();
            a = actual(x.sel);
            n_tests++;
            if (a !== x.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", x.name, a, x.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_m(input string nm, input logic [31:0] res, input logic [31:0] d2,
                            input logic [4:0] wr, input logic [5:0] ctl, input int due);
        push({nm, "_res_m"}, S_RESM, res, due);
        push({nm, "_d2_m"},  S_D2M,  d2, due);
        push({nm, "_wr_m"},  S_WRM,  {27'd0, wr}, due);
        push({nm, "_ctl_m"}, S_CTLM, {26'd0, ctl}, due);
    endtask

    task automatic set_pipe(input logic [31:0] d2, input logic [4:0] wr, input logic [5:0] ctl);
        bus.reg_data2_e = d2;
        bus.write_reg_e = wr;
        {bus.reg_write_e, bus.mem_to_reg_e, bus.mem_write_e,
         bus.mem_read_e, bus.load_full_word_e, bus.load_signed_e} = ctl;
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh);
        bus.alu_op = op; bus.oprd1 = a; bus.oprd2 = b; bus.shamt = sh;
    endtask

    task automatic chk_dec(input string nm, input logic [5:0] opc, input logic [5:0] fn,
                           input logic [3:0] e);
        step();
        bus.opcode = opc; bus.funct = fn;
        push(nm, S_OPD, {28'd0, e}, cyc);
    endtask

    task automatic chk_alu(input string nm, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh, input logic [31:0] e);
        step();
        set_alu(op, a, b, sh);
        push(nm, S_RES, e, cyc);
        push({nm, "_zero"}, S_ZERO, {31'd0, (e == 32'd0)}, cyc);
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.opcode = 6'd0; bus.funct = 6'd0;
        set_alu(4'd0, 32'd0, 32'd0, 5'd0);
        set_pipe(32'd0, 5'd0, 6'd0);

        // reset state
        step();
        expect_m("reset", 32'd0, 32'd0, 5'd0, 6'd0, cyc);
        reset = 1'b0;

        // decoder sweep
        chk_dec("dec_addi",   6'h08, 6'h00, 4'd2);
        chk_dec("dec_sub",    6'h00, 6'h22, 4'd6);
        chk_dec("dec_srl",    6'h00, 6'h02, 4'd4);
        chk_dec("dec_sw",     6'h2B, 6'h00, 4'd2);
        chk_dec("dec_beq",    6'h04, 6'h00, 4'd6);
        chk_dec("dec_unk",    6'h3F, 6'h00, 4'd2);
        chk_dec("dec_and",    6'h00, 6'h24, 4'd0);
        chk_dec("dec_or",     6'h00, 6'h25, 4'd1);
        chk_dec("dec_xor",    6'h00, 6'h26, 4'd9);
        chk_dec("dec_nor",    6'h00, 6'h27, 4'd12);
        chk_dec("dec_slt",    6'h00, 6'h2A, 4'd7);
        chk_dec("dec_sltu",   6'h00, 6'h2B, 4'd8);
        chk_dec("dec_sll",    6'h00, 6'h00, 4'd3);
        chk_dec("dec_sra",    6'h00, 6'h03, 4'd5);
        chk_dec("dec_subu",   6'h00, 6'h23, 4'd6);
        chk_dec("dec_rdef",   6'h00, 6'h3F, 4'd2);
        chk_dec("dec_slti",   6'h0A, 6'h00, 4'd7);
        chk_dec("dec_sltiu",  6'h0B, 6'h00, 4'd8);
        chk_dec("dec_andi",   6'h0C, 6'h00, 4'd0);
        chk_dec("dec_ori",    6'h0D, 6'h00, 4'd1);
        chk_dec("dec_xori",   6'h0E, 6'h00, 4'd9);
        chk_dec("dec_bne",    6'h05, 6'h00, 4'd6);
        chk_dec("dec_lw",     6'h23, 6'h2A, 4'd2);

        // ALU arithmetic, logic and shifts
        chk_alu("add",      4'd2,  32'd0,          32'd5,          5'd3,  32'd5);
        chk_alu("sub",      4'd6,  32'd5,          32'd2,          5'd0,  32'd3);
        chk_alu("sub_zero", 4'd6,  32'd7,          32'd7,          5'd0,  32'd0);
        chk_alu("add_wrap", 4'd2,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0);
        chk_alu("slt",      4'd7,  32'hFFFF_FFFD,  32'd2,          5'd0,  32'd1);
        chk_alu("sltu",     4'd8,  32'hFFFF_FFFD,  32'd2,          5'd0,  32'd0);
        chk_alu("slt_neg",  4'd7,  32'd2,          32'hFFFF_FFFD,  5'd0,  32'd0);
        chk_alu("sltu_t",   4'd8,  32'd2,          32'hFFFF_FFFD,  5'd0,  32'd1);
        chk_alu("srl",      4'd4,  32'h1234_5678,  32'd5,          5'd1,  32'd2);
        chk_alu("sra",      4'd5,  32'd0,          32'h8000_0000,  5'd4,  32'hF800_0000);
        chk_alu("sll",      4'd3,  32'hDEAD_BEEF,  32'd1,          5'd31, 32'h8000_0000);
        chk_alu("and",      4'd0,  32'hF0F0_1234,  32'h0FF0_FFFF,  5'd0,  32'h00F0_1234);
        chk_alu("or",       4'd1,  32'hF000_0001,  32'h0000_0F00,  5'd0,  32'hF000_0F01);
        chk_alu("xor",      4'd9,  32'hFFFF_0000,  32'h0F0F_0F0F,  5'd0,  32'hF0F0_0F0F);
        chk_alu("nor",      4'd12, 32'hFFFF_0000,  32'h0000_FF00,  5'd0,  32'h0000_00FF);
        chk_alu("bad_op",   4'd10, 32'h1111_1111,  32'h2222_2222,  5'd1,  32'd0);

        // idle register still holds reset contents (enable was 0 throughout)
        push("idle_hold_res_m", S_RESM, 32'd0, cyc);

        // pipeline capture
        step();
        bus.enable = 1'b1;
        set_alu(4'd2, 32'd0, 32'd5, 5'd0);
        set_pipe(32'd0, 5'd0, 6'b001000);
        expect_m("cap1", 32'd5, 32'd0, 5'd0, 6'b001000, cyc + 1);

        step();
        set_alu(4'd6, 32'd10, 32'd3, 5'd0);
        set_pipe(32'hDEAD_BEEF, 5'd31, 6'b110111);
        expect_m("cap2", 32'd7, 32'hDEAD_BEEF, 5'd31, 6'b110111, cyc + 1);

        // enable hold across two edges with changed inputs
        step();
        bus.enable = 1'b0;
        set_alu(4'd9, 32'hAAAA_AAAA, 32'h5555_5555, 5'd0);
        set_pipe(32'h0BAD_F00D, 5'd7, 6'b001000);
        expect_m("hold1", 32'd7, 32'hDEAD_BEEF, 5'd31, 6'b110111, cyc + 1);
        expect_m("hold2", 32'd7, 32'hDEAD_BEEF, 5'd31, 6'b110111, cyc + 2);
        step();

        // capture, then assert reset between edges, then recover
        step();
        bus.enable = 1'b1;
        set_alu(4'd2, 32'd1, 32'd1, 5'd0);
        set_pipe(32'h1234_5678, 5'd3, 6'b100000);
        expect_m("cap3", 32'd2, 32'h1234_5678, 5'd3, 6'b100000, cyc + 1);

        step();
        reset = 1'b1;
        expect_m("rst_mid", 32'd2, 32'h1234_5678, 5'd3, 6'b100000, cyc);
        expect_m("rst_edge", 32'd0, 32'd0, 5'd0, 6'd0, cyc + 1);

        step();
        reset = 1'b0;
        expect_m("rst_recover", 32'd2, 32'h1234_5678, 5'd3, 6'b100000, cyc + 1);

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
